sipo_frame_ctrl: RTL and testbench

Frame-level controller for serial-in/parallel-out capture: sequences a WIDTH-bit shift register through idle, shift and hold phases, and hands each completed word to a downstream consumer over a valid/ready handshake. It sits between a serial bit source and parallel logic, sequencing the deserializing datapath so frames are counted, framed and never silently overwritten.

---
 rtl/sipo_frame_ctrl_if.sv | 21 ++
 rtl/sipo_frame_ctrl.sv | 103 ++++++++++
 tb/tb_sipo_frame_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/sipo_frame_ctrl_if.sv
// Parallel-word handshake between the SIPO frame controller and its consumer.
// The master side drives the captured word and its valid flag; the slave side returns ready.
interface sipo_frame_ctrl_if #(
   parameter int WIDTH = 4
) ();
   logic [WIDTH-1:0] data_out;
   logic             data_valid;
   logic             out_ready;

   modport master (
      output data_out,
      output data_valid,
      input  out_ready
   );

   modport slave (
      input  data_out,
      input  data_valid,
      output out_ready
   );
endinterface

// File: rtl/sipo_frame_ctrl.sv
// Frame controller for serial-in/parallel-out capture with valid/ready hand-off.
// Define SIPO_CTRL_PARITY_EN to add a trailing even-parity bit and the parity_err flag.
module sipo_frame_ctrl #(
   parameter  int WIDTH = 4,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 data_in,
   sipo_frame_ctrl_if.master    out_bus,
   output logic                 busy,
   output logic [CNT_W-1:0]     bit_cnt,
   output logic                 overrun,
   output logic                 parity_err
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2,
      HOLD   = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] data_out_q;
   logic             data_valid_q;
   logic             last_bit;
   logic             shift_en;
   logic             frame_start;
   logic             overrun_nxt;

   assign last_bit           = (bit_cnt == LAST_CNT);
   assign out_bus.data_out   = data_out_q;
   assign out_bus.data_valid = data_valid_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:   if (start) state_nxt = SHIFT;
         SHIFT: begin
            if (last_bit) begin
`ifdef SIPO_CTRL_PARITY_EN
               state_nxt = PARITY;
`else
               state_nxt = HOLD;
`endif
            end
         end
         PARITY: state_nxt = HOLD;
         HOLD:   if (out_bus.out_ready) state_nxt = start ? SHIFT : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Control strobes decoded from the current state and inputs.
   always_comb begin
      busy        = (state != IDLE);
      shift_en    = (state == SHIFT);
      frame_start = start && ((state == IDLE) || (state == HOLD && out_bus.out_ready));
      overrun_nxt = start && ((state == SHIFT) || (state == PARITY) ||
                              (state == HOLD && !out_bus.out_ready));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         bit_cnt      <= '0;
         overrun      <= 1'b0;
      end else begin
         // First bit received drifts down to bit 0 by the end of the frame.
         if (shift_en) data_out_q <= {data_in, data_out_q[WIDTH-1:1]};

         if (frame_start)   bit_cnt <= '0;
         else if (shift_en) bit_cnt <= last_bit ? '0 : bit_cnt + CNT_W'(1);

         data_valid_q <= (state_nxt == HOLD);
         overrun      <= overrun_nxt;
      end
   end

`ifdef SIPO_CTRL_PARITY_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                  parity_err <= 1'b0;
      else if (frame_start)        parity_err <= 1'b0;
      else if (state == PARITY)    parity_err <= (^data_out_q) ^ data_in;
   end
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed bench for sipo_frame_ctrl: a per-edge vector table plus hand-written
// sequences for asynchronous reset and the optional parity phase.
module tb_sipo_frame_ctrl;
   localparam int W = 4;
`ifdef SIPO_CTRL_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   logic       clk;
   logic       reset;
   logic       start;
   logic       data_in;
   logic       busy;
   logic [1:0] bit_cnt;
   logic       overrun;
   logic       parity_err;

   int n_tests = 0;
   int n_fail  = 0;

   sipo_frame_ctrl_if #(.WIDTH(W)) bus ();

   sipo_frame_ctrl #(.WIDTH(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .data_in    (data_in),
      .out_bus    (bus.master),
      .busy       (busy),
      .bit_cnt    (bit_cnt),
      .overrun    (overrun),
      .parity_err (parity_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       start;
      logic       din;
      logic       rdy;
      logic [3:0] exp_data;
      logic       exp_valid;
      logic       exp_busy;
      logic [1:0] exp_cnt;
      logic       exp_ovr;
   } vec_t;

   vec_t tbl[29];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Apply inputs on the falling edge, then settle just past the next rising edge.
   task automatic drive(input logic s, input logic d, input logic r);
      @(negedge clk);
      start         = s;
      data_in       = d;
      bus.out_ready = r;
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [3:0] d, input logic v,
                            input logic b, input logic [1:0] c, input logic o, input logic p);
      check({tag, ".data"},  32'(bus.data_out),   32'(d));
      check({tag, ".valid"}, 32'(bus.data_valid), 32'(v));
      check({tag, ".busy"},  32'(busy),           32'(b));
      check({tag, ".cnt"},   32'(bit_cnt),        32'(c));
      check({tag, ".ovr"},   32'(overrun),        32'(o));
      check({tag, ".perr"},  32'(parity_err),     32'(p));
   endtask

   initial begin
      logic [3:0] bits;

      reset         = 1'b0;
      start         = 1'b0;
      data_in       = 1'b0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_all("reset", 4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b1;

`ifndef SIPO_CTRL_PARITY_EN
      //            start din  rdy   data     v     b     cnt   ovr
      tbl[0]  = '{1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 2'd0, 1'b0};
      tbl[1]  = '{1'b0, 1'b1, 1'b1, 4'h8, 1'b0, 1'b1, 2'd1, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 1'b1, 4'h4, 1'b0, 1'b1, 2'd2, 1'b0};
      tbl[3]  = '{1'b0, 1'b1, 1'b1, 4'hA, 1'b0, 1'b1, 2'd3, 1'b0};
      tbl[4]  = '{1'b0, 1'b1, 1'b1, 4'hD, 1'b1, 1'b1, 2'd0, 1'b0};
      tbl[5]  = '{1'b0, 1'b0, 1'b1, 4'hD, 1'b0, 1'b0, 2'd0, 1'b0};
      tbl[6]  = '{1'b0, 1'b0, 1'b1, 4'hD, 1'b0, 1'b0, 2'd0, 1'b0};
      // backpressure: same frame, five HOLD cycles with ready low, start dropped once
      tbl[7]  = '{1'b1, 1'b0, 1'b0, 4'hD, 1'b0, 1'b1, 2'd0, 1'b0};
      tbl[8]  = '{1'b0, 1'b1, 1'b0, 4'hE, 1'b0, 1'b1, 2'd1, 1'b0};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 4'h7, 1'b0, 1'b1, 2'd2, 1'b0};
      tbl[10] = '{1'b0, 1'b1, 1'b0, 4'hB, 1'b0, 1'b1, 2'd3, 1'b0};
      tbl[11] = '{1'b0, 1'b1, 1'b0, 4'hD, 1'b1, 1'b1, 2'd0, 1'b0};
      tbl[12] = '{1'b0, 1'b0, 1'b0, 4'hD, 1'b1, 1'b1, 2'd0, 1'b0};
      tbl[13] = '{1'b1, 1'b0, 1'b0, 4'hD, 1'b1, 1'b1, 2'd0, 1'b1};
      tbl[14] = '{1'b0, 1'b0, 1'b0, 4'hD, 1'b1, 1'b1, 2'd0, 1'b0};
      tbl[15] = '{1'b0, 1'b0, 1'b0, 4'hD, 1'b1, 1'b1, 2'd0, 1'b0};
      tbl[16] = '{1'b0, 1'b0, 1'b0, 4'hD, 1'b1, 1'b1, 2'd0, 1'b0};
      tbl[17] = '{1'b0, 1'b0, 1'b1, 4'hD, 1'b0, 1'b0, 2'd0, 1'b0};
      // start during SHIFT is dropped, then a back-to-back frame 0,1,1,0
      tbl[18] = '{1'b1, 1'b0, 1'b1, 4'hD, 1'b0, 1'b1, 2'd0, 1'b0};
      tbl[19] = '{1'b0, 1'b1, 1'b1, 4'hE, 1'b0, 1'b1, 2'd1, 1'b0};
      tbl[20] = '{1'b1, 1'b0, 1'b1, 4'h7, 1'b0, 1'b1, 2'd2, 1'b1};
      tbl[21] = '{1'b0, 1'b1, 1'b1, 4'hB, 1'b0, 1'b1, 2'd3, 1'b0};
      tbl[22] = '{1'b0, 1'b1, 1'b1, 4'hD, 1'b1, 1'b1, 2'd0, 1'b0};
      tbl[23] = '{1'b1, 1'b0, 1'b1, 4'hD, 1'b0, 1'b1, 2'd0, 1'b0};
      tbl[24] = '{1'b0, 1'b0, 1'b1, 4'h6, 1'b0, 1'b1, 2'd1, 1'b0};
      tbl[25] = '{1'b0, 1'b1, 1'b1, 4'hB, 1'b0, 1'b1, 2'd2, 1'b0};
      tbl[26] = '{1'b0, 1'b1, 1'b1, 4'hD, 1'b0, 1'b1, 2'd3, 1'b0};
      tbl[27] = '{1'b0, 1'b0, 1'b1, 4'h6, 1'b1, 1'b1, 2'd0, 1'b0};
      tbl[28] = '{1'b0, 1'b0, 1'b1, 4'h6, 1'b0, 1'b0, 2'd0, 1'b0};

      for (int i = 0; i < 29; i++) begin
         drive(tbl[i].start, tbl[i].din, tbl[i].rdy);
         check_all($sformatf("vec%0d", i), tbl[i].exp_data, tbl[i].exp_valid,
                   tbl[i].exp_busy, tbl[i].exp_cnt, tbl[i].exp_ovr, 1'b0);
      end
`endif

      // Mid-frame asynchronous reset, then a clean frame 1,1,0,0 -> 4'b0011.
      drive(1'b1, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b1);
      check("mid.cnt_before", 32'(bit_cnt), 32'd2);
      #2 reset = 1'b0;
      #1;
      check_all("mid.async", 4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      drive(1'b1, 1'b0, 1'b1);
      check_all("rf.e0", 4'h0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
      bits = 4'b0011;
      for (int i = 0; i < W; i++) begin
         drive(1'b0, bits[i], 1'b1);
         check($sformatf("rf.cnt%0d", i), 32'(bit_cnt), 32'((i + 1) % W));
      end
      if (PAR == 1) begin
         check("rf.valid_late", 32'(bus.data_valid), 32'd0);
         drive(1'b0, 1'b0, 1'b1);
      end
      check_all("rf.hold", 4'h3, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1);
      check_all("rf.idle", 4'h3, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);

`ifdef SIPO_CTRL_PARITY_EN
      // Good parity: 1,0,1,1 + parity 1; start during PARITY is dropped.
      drive(1'b1, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 1'b1);
      drive(1'b0, 1'b1, 1'b1);
      check("p1.valid_late", 32'(bus.data_valid), 32'd0);
      drive(1'b1, 1'b1, 1'b0);
      check_all("p1.hold", 4'hD, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b1);
      check("p1.done", 32'(busy), 32'd0);
      // Bad parity: parity bit 0, held under backpressure, cleared by a back-to-back start.
      drive(1'b1, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 1'b1);
      drive(1'b0, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b0);
      check_all("p0.hold", 4'hD, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0);
      check("p0.perr_held", 32'(parity_err), 32'd1);
      drive(1'b1, 1'b0, 1'b1);
      check_all("p0.restart", 4'hD, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
